// File: rtl/rcu_rx_ctrl_if.sv
// Handshake bundle between the receive datapath counters/checker and rcu_rx_ctrl.
// err_count exists only when RCU_ERR_COUNT_EN is defined.
interface rcu_rx_ctrl_if;
   logic       start_bit_detected;
   logic       packet_done;
   logic       framing_error;
   logic       sbc_clear;
   logic       sbc_enable;
   logic       enable_timer;
   logic       load_buffer;
   logic       rx_abort;
`ifdef RCU_ERR_COUNT_EN
   logic [7:0] err_count;
`endif

   // Datapath side: supplies detector/counter/checker status, consumes controls.
   modport master (
      output start_bit_detected, packet_done, framing_error,
`ifdef RCU_ERR_COUNT_EN
      input  err_count,
`endif
      input  sbc_clear, sbc_enable, enable_timer, load_buffer, rx_abort
   );

   // Controller side.
   modport slave (
      input  start_bit_detected, packet_done, framing_error,
`ifdef RCU_ERR_COUNT_EN
      output err_count,
`endif
      output sbc_clear, sbc_enable, enable_timer, load_buffer, rx_abort
   );
endinterface

// File: rtl/rcu_rx_ctrl.sv
// Receiver control FSM with RECEIVE watchdog; Moore outputs decoded from state.
// Optional framing/abort error counter enabled by defining RCU_ERR_COUNT_EN.
module rcu_rx_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 128,
   parameter int unsigned TO_WIDTH       = 8
) (
   input logic           clk,
   input logic           n_rst,
   rcu_rx_ctrl_if.slave  bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START_CLR = 3'd1;
   localparam logic [2:0] RECEIVE   = 3'd2;
   localparam logic [2:0] STOP_CHK  = 3'd3;
   localparam logic [2:0] ERR_WAIT  = 3'd4;
   localparam logic [2:0] LOAD      = 3'd5;
   localparam logic [2:0] ABORT     = 3'd6;

   localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [2:0]          state, next_state;
   logic [TO_WIDTH-1:0] wd_count;
   logic                wd_expired;

   // packet_done wins over expiry, so expiry alone is qualified by !packet_done.
   assign wd_expired = (wd_count == WD_LAST) && !bus.packet_done;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (bus.start_bit_detected) next_state = START_CLR;
         START_CLR: next_state = RECEIVE;
         RECEIVE: begin
            if (bus.packet_done)  next_state = STOP_CHK;
            else if (wd_expired)  next_state = ABORT;
         end
         STOP_CHK:  next_state = ERR_WAIT;
         ERR_WAIT:  next_state = bus.framing_error ? IDLE : LOAD;
         LOAD:      next_state = IDLE;
         ABORT:     next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= next_state;
   end

   // Cleared on entry to RECEIVE, counts while there, held elsewhere.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         wd_count <= '0;
      else if (state == START_CLR)
         wd_count <= '0;
      else if (state == RECEIVE && wd_count != WD_LAST)
         wd_count <= wd_count + 1'b1;
   end

   always_comb begin
      bus.sbc_clear    = (state == START_CLR) || (state == ABORT);
      bus.sbc_enable   = (state == STOP_CHK);
      bus.enable_timer = (state == RECEIVE);
      bus.load_buffer  = (state == LOAD);
      bus.rx_abort     = (state == ABORT);
   end

`ifdef RCU_ERR_COUNT_EN
   logic       err_event;
   logic [7:0] err_count_r;

   assign err_event = ((state == ERR_WAIT) && bus.framing_error) ||
                      ((state == RECEIVE) && wd_expired);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         err_count_r <= '0;
      else if (err_event && err_count_r != '1)
         err_count_r <= err_count_r + 1'b1;
   end

   assign bus.err_count = err_count_r;
`endif

endmodule

// File: tb/tb_rcu_rx_ctrl.sv
// Directed bench for rcu_rx_ctrl (TIMEOUT_CYCLES=16); outputs checked as
// {sbc_clear, sbc_enable, enable_timer, load_buffer, rx_abort}.
module tb_rcu_rx_ctrl;
   logic clk;
   logic n_rst;
   int   n_checks;
   int   n_pass;

   rcu_rx_ctrl_if bus();

   rcu_rx_ctrl #(.TIMEOUT_CYCLES(16), .TO_WIDTH(8)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [4:0] O_IDLE  = 5'b00000;
   localparam logic [4:0] O_CLR   = 5'b10000;
   localparam logic [4:0] O_STOP  = 5'b01000;
   localparam logic [4:0] O_RECV  = 5'b00100;
   localparam logic [4:0] O_LOAD  = 5'b00010;
   localparam logic [4:0] O_ABORT = 5'b10001;

   function automatic logic [4:0] outs();
      return {bus.sbc_clear, bus.sbc_enable, bus.enable_timer,
              bus.load_buffer, bus.rx_abort};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_rst    = 1'b0;
      bus.start_bit_detected = 1'b0;
      bus.packet_done        = 1'b0;
      bus.framing_error      = 1'b0;
      tick();
      tick();
      check("reset_outs", {3'b0, outs()}, {3'b0, O_IDLE});
`ifdef RCU_ERR_COUNT_EN
      check("reset_errcnt", bus.err_count, 8'd0);
`endif
      n_rst = 1'b1;
      tick();

      // packet_done outside RECEIVE is ignored
      bus.packet_done = 1'b1;
      tick();
      bus.packet_done = 1'b0;
      check("idle_pd_ignored", {3'b0, outs()}, {3'b0, O_IDLE});

      // Good packet
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      check("good_start_clr", {3'b0, outs()}, {3'b0, O_CLR});
      tick();
      check("good_recv", {3'b0, outs()}, {3'b0, O_RECV});
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      check("recv_start_ignored", {3'b0, outs()}, {3'b0, O_RECV});
      tick();
      check("recv_hold", {3'b0, outs()}, {3'b0, O_RECV});
      bus.packet_done = 1'b1;
      tick();
      bus.packet_done = 1'b0;
      check("good_stop_chk", {3'b0, outs()}, {3'b0, O_STOP});
      tick();
      check("good_err_wait", {3'b0, outs()}, {3'b0, O_IDLE});
      tick();
      check("good_load", {3'b0, outs()}, {3'b0, O_LOAD});
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      check("good_idle", {3'b0, outs()}, {3'b0, O_IDLE});
      tick();
      check("load_start_lost", {3'b0, outs()}, {3'b0, O_IDLE});

      // Framing error
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      check("fe_start_clr", {3'b0, outs()}, {3'b0, O_CLR});
      tick();
      check("fe_recv", {3'b0, outs()}, {3'b0, O_RECV});
      bus.packet_done = 1'b1;
      tick();
      bus.packet_done = 1'b0;
      check("fe_stop_chk", {3'b0, outs()}, {3'b0, O_STOP});
      tick();
      check("fe_err_wait", {3'b0, outs()}, {3'b0, O_IDLE});
      bus.framing_error = 1'b1;
      tick();
      bus.framing_error = 1'b0;
      check("fe_idle_no_load", {3'b0, outs()}, {3'b0, O_IDLE});
      tick();
      check("fe_idle_hold", {3'b0, outs()}, {3'b0, O_IDLE});
`ifdef RCU_ERR_COUNT_EN
      check("fe_errcnt", bus.err_count, 8'd1);
`endif

      // Watchdog: abort 16 cycles after enable_timer rises
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      tick();
      check("wd_recv_rise", {3'b0, outs()}, {3'b0, O_RECV});
      for (int i = 1; i <= 15; i++) begin
         tick();
         check($sformatf("wd_recv_%0d", i), {3'b0, outs()}, {3'b0, O_RECV});
      end
      tick();
      check("wd_abort", {3'b0, outs()}, {3'b0, O_ABORT});
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      check("wd_idle", {3'b0, outs()}, {3'b0, O_IDLE});
      tick();
      check("abort_start_lost", {3'b0, outs()}, {3'b0, O_IDLE});
`ifdef RCU_ERR_COUNT_EN
      check("wd_errcnt", bus.err_count, 8'd2);
`endif

      // Race: packet_done coincides with expiry
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      tick();
      for (int i = 1; i <= 15; i++) tick();
      check("race_pre", {3'b0, outs()}, {3'b0, O_RECV});
      bus.packet_done = 1'b1;
      tick();
      bus.packet_done = 1'b0;
      check("race_stop_chk", {3'b0, outs()}, {3'b0, O_STOP});
      tick();
      check("race_err_wait", {3'b0, outs()}, {3'b0, O_IDLE});
      tick();
      check("race_load", {3'b0, outs()}, {3'b0, O_LOAD});
      tick();
      check("race_idle", {3'b0, outs()}, {3'b0, O_IDLE});
`ifdef RCU_ERR_COUNT_EN
      check("race_errcnt", bus.err_count, 8'd2);
`endif

      // Asynchronous reset mid-RECEIVE
      bus.start_bit_detected = 1'b1;
      tick();
      bus.start_bit_detected = 1'b0;
      tick();
      tick();
      check("rst_pre_recv", {3'b0, outs()}, {3'b0, O_RECV});
      #2;
      n_rst = 1'b0;
      #1;
      check("rst_async_outs", {3'b0, outs()}, {3'b0, O_IDLE});
`ifdef RCU_ERR_COUNT_EN
      check("rst_async_errcnt", bus.err_count, 8'd0);
`endif
      #1;
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_post_%0d", i), {3'b0, outs()}, {3'b0, O_IDLE});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
